// File: rtl/pipe_em_stage_if.sv
// EX->MEM beat bundle: valid/ready handshake plus the control and data payload.
// The master drives valid and payload and samples ready; the slave does the opposite.
interface pipe_em_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          valid;
    logic          ready;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [DW-1:0] alu;
    logic [DW-1:0] b;
    logic [RW-1:0] rn;

    modport master (
        output valid, wreg, m2reg, wmem, alu, b, rn,
        input  ready
    );

    modport slave (
        input  valid, wreg, m2reg, wmem, alu, b, rn,
        output ready
    );
endinterface

// File: rtl/pipe_em_stage.sv
// EX->MEM pipeline stage register with valid/ready flow control, flush and a
// saturating stall counter.
// Build option PIPE_EM_SKID_EN adds a one-entry skid buffer behind the main
// register so that e_ready comes straight from a flop.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no beat held, m_valid = 0
// ST_FULL  | main register holds a beat, skid empty
// ST_SKID  | main and skid both hold beats (skid build only)
module pipe_em_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  flush,
    pipe_em_stage_if.slave        ex,
    pipe_em_stage_if.master       mem,
    output logic [CW-1:0]         stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t        state;
    logic          m_valid_q;
    logic          mwreg_q;
    logic          mm2reg_q;
    logic          mwmem_q;
    logic [DW-1:0] malu_q;
    logic [DW-1:0] mb_q;
    logic [RW-1:0] mrn_q;
    logic          accept;
    logic          consume;

`ifdef PIPE_EM_SKID_EN
    logic          e_ready_q;
    logic          sk_wreg;
    logic          sk_m2reg;
    logic          sk_wmem;
    logic [DW-1:0] sk_alu;
    logic [DW-1:0] sk_b;
    logic [RW-1:0] sk_rn;

    // e_ready is a flop so no path exists from mem.ready back to ex.ready
    assign ex.ready = e_ready_q;
`else
    assign ex.ready = mem.ready | ~m_valid_q;
`endif

    assign accept  = ex.valid & ex.ready;
    assign consume = m_valid_q & mem.ready;

    assign mem.valid = m_valid_q;
    assign mem.wreg  = mwreg_q;
    assign mem.m2reg = mm2reg_q;
    assign mem.wmem  = mwmem_q;
    assign mem.alu   = malu_q;
    assign mem.b     = mb_q;
    assign mem.rn    = mrn_q;

    // Occupancy FSM and stage registers; controls are cleared whenever the beat leaves
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_EMPTY;
            m_valid_q <= 1'b0;
            mwreg_q   <= 1'b0;
            mm2reg_q  <= 1'b0;
            mwmem_q   <= 1'b0;
            malu_q    <= '0;
            mb_q      <= '0;
            mrn_q     <= '0;
`ifdef PIPE_EM_SKID_EN
            e_ready_q <= 1'b1;
            sk_wreg   <= 1'b0;
            sk_m2reg  <= 1'b0;
            sk_wmem   <= 1'b0;
            sk_alu    <= '0;
            sk_b      <= '0;
            sk_rn     <= '0;
`endif
        end else if (flush) begin
            // Data fields keep stale values; only validity and controls drop
            state     <= ST_EMPTY;
            m_valid_q <= 1'b0;
            mwreg_q   <= 1'b0;
            mm2reg_q  <= 1'b0;
            mwmem_q   <= 1'b0;
`ifdef PIPE_EM_SKID_EN
            e_ready_q <= 1'b1;
            sk_wreg   <= 1'b0;
            sk_m2reg  <= 1'b0;
            sk_wmem   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        m_valid_q <= 1'b1;
                        mwreg_q   <= ex.wreg;
                        mm2reg_q  <= ex.m2reg;
                        mwmem_q   <= ex.wmem;
                        malu_q    <= ex.alu;
                        mb_q      <= ex.b;
                        mrn_q     <= ex.rn;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        mwreg_q   <= ex.wreg;
                        mm2reg_q  <= ex.m2reg;
                        mwmem_q   <= ex.wmem;
                        malu_q    <= ex.alu;
                        mb_q      <= ex.b;
                        mrn_q     <= ex.rn;
`ifdef PIPE_EM_SKID_EN
                    end else if (accept) begin
                        state     <= ST_SKID;
                        e_ready_q <= 1'b0;
                        sk_wreg   <= ex.wreg;
                        sk_m2reg  <= ex.m2reg;
                        sk_wmem   <= ex.wmem;
                        sk_alu    <= ex.alu;
                        sk_b      <= ex.b;
                        sk_rn     <= ex.rn;
`endif
                    end else if (consume) begin
                        state     <= ST_EMPTY;
                        m_valid_q <= 1'b0;
                        mwreg_q   <= 1'b0;
                        mm2reg_q  <= 1'b0;
                        mwmem_q   <= 1'b0;
                    end
                end
`ifdef PIPE_EM_SKID_EN
                ST_SKID: begin
                    // Parked beat moves up before anything new is taken
                    if (consume) begin
                        state     <= ST_FULL;
                        e_ready_q <= 1'b1;
                        mwreg_q   <= sk_wreg;
                        mm2reg_q  <= sk_m2reg;
                        mwmem_q   <= sk_wmem;
                        malu_q    <= sk_alu;
                        mb_q      <= sk_b;
                        mrn_q     <= sk_rn;
                        sk_wreg   <= 1'b0;
                        sk_m2reg  <= 1'b0;
                        sk_wmem   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= ST_EMPTY;
                    m_valid_q <= 1'b0;
                    mwreg_q   <= 1'b0;
                    mm2reg_q  <= 1'b0;
                    mwmem_q   <= 1'b0;
                end
            endcase
        end
    end

    // Count backpressured cycles, sticking at all-ones until reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (m_valid_q && !mem.ready && !flush && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_em_stage.sv
// Directed bench for pipe_em_stage: reset, streaming, stall, flush, bubble
// gating, counter saturation (second instance with CW=2) and mid-stream reset.
// Expectations follow the PIPE_EM_SKID_EN build option where behaviour differs.
module tb_pipe_em_stage;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        flush;
    logic        flush2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int errors = 0;
    int checks = 0;

    pipe_em_stage_if #(.DW(32), .RW(5)) ex_if ();
    pipe_em_stage_if #(.DW(32), .RW(5)) mem_if ();
    pipe_em_stage_if #(.DW(32), .RW(5)) ex2_if ();
    pipe_em_stage_if #(.DW(32), .RW(5)) mem2_if ();

    pipe_em_stage #(.DW(32), .RW(5), .CW(16)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (flush),
        .ex        (ex_if),
        .mem       (mem_if),
        .stall_cnt (stall_cnt)
    );

    pipe_em_stage #(.DW(32), .RW(5), .CW(2)) dut_sat (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (flush2),
        .ex        (ex2_if),
        .mem       (mem2_if),
        .stall_cnt (stall_cnt2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic m2, input logic wm,
                         input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
        ex_if.valid = v;
        ex_if.wreg  = w;
        ex_if.m2reg = m2;
        ex_if.wmem  = wm;
        ex_if.alu   = alu;
        ex_if.b     = b;
        ex_if.rn    = rn;
    endtask

    logic exp_ready_stall;
    int   exp_cnt_flush;

    initial begin
`ifdef PIPE_EM_SKID_EN
        exp_ready_stall = 1'b1;
        exp_cnt_flush   = 4;
`else
        exp_ready_stall = 1'b0;
        exp_cnt_flush   = 3;
`endif
        flush  = 1'b0;
        flush2 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_if.ready  = 1'b1;
        ex2_if.valid  = 1'b0;
        ex2_if.wreg   = 1'b0;
        ex2_if.m2reg  = 1'b0;
        ex2_if.wmem   = 1'b0;
        ex2_if.alu    = 32'h0;
        ex2_if.b      = 32'h0;
        ex2_if.rn     = 5'd0;
        mem2_if.ready = 1'b1;

        // reset state
        #2 resetn = 1'b0;
        #2;
        chk("rst_m_valid", {31'b0, mem_if.valid}, 32'd0);
        chk("rst_mwreg",   {31'b0, mem_if.wreg},  32'd0);
        chk("rst_malu",    mem_if.alu,            32'd0);
        chk("rst_cnt",     {16'b0, stall_cnt},    32'd0);
        tick;
        resetn = 1'b1;
        tick;

        // streaming 1..8 at one beat per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, i, 32'hB0 + i, i[4:0]);
            tick;
            chk($sformatf("stream_malu_%0d", i), mem_if.alu, i);
            chk($sformatf("stream_mrn_%0d", i), {27'b0, mem_if.rn}, i);
            chk($sformatf("stream_valid_%0d", i), {31'b0, mem_if.valid}, 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick;
        chk("stream_drain_valid", {31'b0, mem_if.valid}, 32'd0);
        chk("stream_cnt", {16'b0, stall_cnt}, 32'd0);

        // stall for three cycles
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h111, 5'd3);
        tick;
        chk("stall_load_malu", mem_if.alu, 32'h100);
        mem_if.ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h222, 5'd4);
        #1;
        chk("stall_e_ready_pre", {31'b0, ex_if.ready}, {31'b0, exp_ready_stall});
        tick;
        chk("stall_e_ready_1", {31'b0, ex_if.ready}, 32'd0);
`ifdef PIPE_EM_SKID_EN
        ex_if.valid = 1'b0;
`endif
        tick;
        tick;
        chk("stall_malu",  mem_if.alu, 32'h100);
        chk("stall_mrn",   {27'b0, mem_if.rn}, 32'd3);
        chk("stall_mm2reg", {31'b0, mem_if.m2reg}, 32'd1);
        chk("stall_valid", {31'b0, mem_if.valid}, 32'd1);
        chk("stall_cnt3",  {16'b0, stall_cnt}, 32'd3);
        mem_if.ready = 1'b1;
        tick;
        chk("stall_next_malu", mem_if.alu, 32'h200);
        chk("stall_next_mwmem", {31'b0, mem_if.wmem}, 32'd1);
        ex_if.valid = 1'b0;
        tick;
        chk("stall_drain_valid", {31'b0, mem_if.valid}, 32'd0);
        chk("stall_cnt_hold", {16'b0, stall_cnt}, 32'd3);

        // flush while holding data
        mem_if.ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h333, 5'd5);
        tick;
`ifdef PIPE_EM_SKID_EN
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 32'h555, 5'd7);
        tick;
`endif
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h444, 5'd6);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_valid", {31'b0, mem_if.valid}, 32'd0);
        chk("flush_mwreg", {31'b0, mem_if.wreg},  32'd0);
        chk("flush_mwmem", {31'b0, mem_if.wmem},  32'd0);
        chk("flush_mm2reg", {31'b0, mem_if.m2reg}, 32'd0);
        chk("flush_stale_malu", mem_if.alu, 32'h300);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_if.ready = 1'b1;
        tick;
        chk("flush_after1_valid", {31'b0, mem_if.valid}, 32'd0);
        tick;
        chk("flush_after2_valid", {31'b0, mem_if.valid}, 32'd0);
        chk("flush_cnt", {16'b0, stall_cnt}, exp_cnt_flush);

        // bubble with write controls asserted
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h777, 32'h777, 5'd9);
        tick;
        chk("bubble_valid", {31'b0, mem_if.valid}, 32'd0);
        chk("bubble_mwreg", {31'b0, mem_if.wreg},  32'd0);
        chk("bubble_mwmem", {31'b0, mem_if.wmem},  32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        // saturation on the CW=2 instance
        mem2_if.ready = 1'b0;
        ex2_if.valid  = 1'b1;
        ex2_if.alu    = 32'hA5;
        tick;
        ex2_if.valid  = 1'b0;
        tick;
        tick;
        chk("sat_cnt2", {30'b0, stall_cnt2}, 32'd2);
        for (int i = 0; i < 4; i++) tick;
        chk("sat_cnt_max", {30'b0, stall_cnt2}, 32'd3);
        tick;
        chk("sat_cnt_hold", {30'b0, stall_cnt2}, 32'd3);

        // asynchronous reset while a beat is held
        mem_if.ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h666, 5'd8);
        tick;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("mid_pre_valid", {31'b0, mem_if.valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_valid", {31'b0, mem_if.valid}, 32'd0);
        chk("mid_mwreg", {31'b0, mem_if.wreg},  32'd0);
        chk("mid_mwmem", {31'b0, mem_if.wmem},  32'd0);
        chk("mid_malu",  mem_if.alu,            32'd0);
        chk("mid_mb",    mem_if.b,              32'd0);
        chk("mid_mrn",   {27'b0, mem_if.rn},    32'd0);
        chk("mid_cnt",   {16'b0, stall_cnt},    32'd0);
        chk("mid_cnt2",  {30'b0, stall_cnt2},   32'd0);
        #1 resetn = 1'b1;
        mem_if.ready = 1'b1;
        tick;
        chk("mid_after_valid", {31'b0, mem_if.valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
